trellis_metric_unit: RTL and testbench

- Parametrised successor of the 8-state forward state-metric recursion used in the SISO decoder (LTE turbo constituent code, 13/15 octal).
- Runs either the forward (alpha) or backward (beta) max-log recursion, one trellis step per accepted branch-metric pair, over a block of programmable length.
- Adds saturating arithmetic, valid/ready handshakes on both sides, block framing and per-step metric output.
- Sits between the branch-metric unit and the LLR/extrinsic stage.

---
 rtl/trellis_metric_unit_if.sv | 25 ++
 rtl/trellis_metric_unit.sv | 172 +++++++++++++++++
 tb/tb_trellis_metric_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trellis_metric_unit_if.sv
// Branch-metric input / state-metric output handshake bundle for trellis_metric_unit.
// master drives gammas and out_ready; slave (the unit) drives in_ready and the metric vector.
interface trellis_metric_unit_if #(
   parameter int unsigned GW = 16,
   parameter int unsigned MW = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [GW-1:0] gamma1;
   logic signed [GW-1:0] gamma2;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;
   logic [8*MW-1:0]      metrics;

   modport master (
      output in_valid, gamma1, gamma2, out_ready,
      input  in_ready, out_valid, out_last, metrics
   );

   modport slave (
      input  in_valid, gamma1, gamma2, out_ready,
      output in_ready, out_valid, out_last, metrics
   );
endinterface

// File: rtl/trellis_metric_unit.sv
// 8-state max-log forward/backward state-metric recursion (13/15 octal) with saturation.
// Optional macro TRELLIS_METRIC_NORM_EN: normalise every step to the new state-0 metric.
module trellis_metric_unit #(
   parameter int unsigned GW       = 16,
   parameter int unsigned MW       = 16,
   parameter int unsigned LW       = 16,
   parameter int unsigned INIT_NEG = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic          init_sel,
   input  logic [LW-1:0] blk_len,
   output logic          busy,
   output logic          done,
   trellis_metric_unit_if.slave bus
);
   // One spare bit beyond the add width so the normalising subtract cannot wrap.
   localparam int unsigned EW = ((MW > GW) ? MW : GW) + 2;
   localparam int unsigned NW = EW + 1;

   typedef logic signed [NW-1:0] wide_t;
   typedef logic signed [MW-1:0] met_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam wide_t SAT_MAX  = wide_t'((64'sd1 <<< (MW - 1)) - 64'sd1);
   localparam wide_t SAT_MIN  = -SAT_MAX;
   localparam met_t  NEG_INIT = MW'(-int'(INIT_NEG));

   state_t          state_q;
   logic            mode_q;
   logic [LW-1:0]   len_q;
   logic [LW-1:0]   cnt_q;
   logic [LW-1:0]   cnt_d;
   met_t            met_q [8];
   met_t            met_d [8];
   logic [8*MW-1:0] met_flat_d;
   logic [8*MW-1:0] out_met_q;
   logic            out_valid_q;
   logic            out_last_q;
   logic            busy_q;
   logic            done_q;
   logic            xfer_c;
   logic            last_c;
   wide_t           a [8];
   wide_t           n [8];
   wide_t           g1;
   wide_t           g2;
`ifdef TRELLIS_METRIC_NORM_EN
   wide_t           ref0;
`endif

   function automatic wide_t max2(input wide_t x, input wide_t y);
      return (x >= y) ? x : y;
   endfunction

   function automatic met_t sat(input wide_t x);
      if (x > SAT_MAX) return MW'(SAT_MAX);
      if (x < SAT_MIN) return MW'(SAT_MIN);
      return MW'(x);
   endfunction

   assign bus.in_ready  = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.metrics   = out_met_q;
   assign busy          = busy_q;
   assign done          = done_q;

   assign xfer_c = bus.in_valid && bus.in_ready;
   assign cnt_d  = cnt_q + LW'(1);
   assign last_c = (cnt_d == len_q);

   // Add-compare-select for one trellis step, then optional normalise and saturate.
   always_comb begin
      g1 = wide_t'(bus.gamma1);
      g2 = wide_t'(bus.gamma2);
      for (int s = 0; s < 8; s++) begin
         a[s] = wide_t'(met_q[s]);
      end
      if (!mode_q) begin
         n[0] = max2(a[0] + g1, a[1] - g1);
         n[1] = max2(a[2] - g2, a[3] + g2);
         n[2] = max2(a[4] + g2, a[5] - g2);
         n[3] = max2(a[6] - g1, a[7] + g1);
         n[4] = max2(a[0] - g1, a[1] + g1);
         n[5] = max2(a[2] + g2, a[3] - g2);
         n[6] = max2(a[4] - g2, a[5] + g2);
         n[7] = max2(a[6] + g1, a[7] - g1);
      end else begin
         n[0] = max2(a[0] + g1, a[4] - g1);
         n[1] = max2(a[0] - g1, a[4] + g1);
         n[2] = max2(a[1] - g2, a[5] + g2);
         n[3] = max2(a[1] + g2, a[5] - g2);
         n[4] = max2(a[2] + g2, a[6] - g2);
         n[5] = max2(a[2] - g2, a[6] + g2);
         n[6] = max2(a[3] - g1, a[7] + g1);
         n[7] = max2(a[3] + g1, a[7] - g1);
      end
`ifdef TRELLIS_METRIC_NORM_EN
      ref0 = n[0];
      for (int s = 0; s < 8; s++) begin
         n[s] = n[s] - ref0;
      end
`endif
      met_flat_d = '0;
      for (int s = 0; s < 8; s++) begin
         met_d[s]                 = sat(n[s]);
         met_flat_d[s*MW +: MW]   = met_d[s];
      end
   end

   // Block-control FSM with registered handshake, framing and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
         out_met_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int s = 0; s < 8; s++) begin
            met_q[s] <= (s == 0) ? '0 : NEG_INIT;
         end
      end else begin
         done_q <= 1'b0;
         if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  len_q   <= blk_len;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= (blk_len == '0) ? S_DONE : S_RUN;
                  for (int s = 0; s < 8; s++) begin
                     met_q[s] <= (init_sel || s == 0) ? '0 : NEG_INIT;
                  end
               end
            end
            S_RUN: begin
               if (xfer_c) begin
                  for (int s = 0; s < 8; s++) begin
                     met_q[s] <= met_d[s];
                  end
                  out_met_q   <= met_flat_d;
                  out_valid_q <= 1'b1;
                  out_last_q  <= last_c;
                  cnt_q       <= cnt_d;
                  if (last_c) state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (out_valid_q && bus.out_ready) state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_trellis_metric_unit.sv
// Scoreboard bench for trellis_metric_unit: a reference recursion model predicts every
// metric vector at input-transfer time; predictions are compared at output acceptance.
module tb_trellis_metric_unit;
   localparam int unsigned GW  = 16;
   localparam int unsigned MW  = 16;
   localparam int unsigned LW  = 16;
   localparam int unsigned MW8 = 8;

   typedef struct packed { logic last; logic [8*MW-1:0]  met; } exp_t;
   typedef struct packed { logic last; logic [8*MW8-1:0] met; } exp8_t;

   logic          clk;
   logic          rst;
   logic          start, mode, init_sel, busy, done;
   logic [LW-1:0] blk_len;
   logic          s8_start, s8_mode, s8_init, s8_busy, s8_done;
   logic [LW-1:0] s8_len;

   trellis_metric_unit_if #(.GW(GW), .MW(MW))  bus ();
   trellis_metric_unit_if #(.GW(GW), .MW(MW8)) bus8 ();

   trellis_metric_unit #(.GW(GW), .MW(MW), .LW(LW), .INIT_NEG(128)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .init_sel(init_sel),
      .blk_len(blk_len), .busy(busy), .done(done), .bus(bus)
   );

   trellis_metric_unit #(.GW(GW), .MW(MW8), .LW(LW), .INIT_NEG(128)) dut8 (
      .clk(clk), .rst(rst), .start(s8_start), .mode(s8_mode), .init_sel(s8_init),
      .blk_len(s8_len), .busy(s8_busy), .done(s8_done), .bus(bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int              nchk = 0;
   int              npass = 0;
   exp_t            sb [$];
   int              mdl [8];
   bit              mdl_mode;
   int              mdl_k;
   int              mdl_n;
   logic [8*MW-1:0] act_met;
   logic            act_last;
   logic            act_ir;

   function automatic int mx(input int x, input int y);
      return (x >= y) ? x : y;
   endfunction

   task automatic model_step(input int mi [8], input bit md, input int g1, input int g2,
                             input int mw, output int mo [8]);
      int nn [8];
      int lim;
`ifdef TRELLIS_METRIC_NORM_EN
      int r;
`endif
      if (!md) begin
         nn[0] = mx(mi[0] + g1, mi[1] - g1);  nn[4] = mx(mi[0] - g1, mi[1] + g1);
         nn[1] = mx(mi[2] - g2, mi[3] + g2);  nn[5] = mx(mi[2] + g2, mi[3] - g2);
         nn[2] = mx(mi[4] + g2, mi[5] - g2);  nn[6] = mx(mi[4] - g2, mi[5] + g2);
         nn[3] = mx(mi[6] - g1, mi[7] + g1);  nn[7] = mx(mi[6] + g1, mi[7] - g1);
      end else begin
         nn[0] = mx(mi[0] + g1, mi[4] - g1);  nn[1] = mx(mi[0] - g1, mi[4] + g1);
         nn[2] = mx(mi[1] - g2, mi[5] + g2);  nn[3] = mx(mi[1] + g2, mi[5] - g2);
         nn[4] = mx(mi[2] + g2, mi[6] - g2);  nn[5] = mx(mi[2] - g2, mi[6] + g2);
         nn[6] = mx(mi[3] - g1, mi[7] + g1);  nn[7] = mx(mi[3] + g1, mi[7] - g1);
      end
      lim = (1 << (mw - 1)) - 1;
`ifdef TRELLIS_METRIC_NORM_EN
      r = nn[0];
      for (int s = 0; s < 8; s++) nn[s] = nn[s] - r;
`endif
      for (int s = 0; s < 8; s++) begin
         mo[s] = (nn[s] > lim) ? lim : ((nn[s] < -lim) ? -lim : nn[s]);
      end
   endtask

   function automatic logic [8*MW-1:0] pack16(input int v [8]);
      logic [8*MW-1:0] r;
      for (int s = 0; s < 8; s++) r[s*MW +: MW] = MW'(v[s]);
      return r;
   endfunction

   function automatic logic [8*MW8-1:0] pack8(input int v [8]);
      logic [8*MW8-1:0] r;
      for (int s = 0; s < 8; s++) r[s*MW8 +: MW8] = MW8'(v[s]);
      return r;
   endfunction

   // Caller sits at posedge+1; block starts on the next edge.
   task automatic do_start(input bit md, input bit is, input int k);
      start = 1'b1; mode = md; init_sel = is; blk_len = LW'(k);
      @(posedge clk); #1;
      start = 1'b0;
      mdl_mode = md; mdl_k = k; mdl_n = 0;
      for (int s = 0; s < 8; s++) mdl[s] = (is || s == 0) ? 0 : -128;
      sb.delete();
   endtask

   // One cycle: drive, sample handshakes mid-cycle, push predictions on transfer.
   task automatic tick(input bit iv, input int g1, input int g2, input bit ordy,
                       output bit xf, output bit ac);
      int   mo [8];
      exp_t e;
      bus.in_valid = iv; bus.gamma1 = GW'(g1); bus.gamma2 = GW'(g2); bus.out_ready = ordy;
      #3;
      xf = iv && bus.in_ready;
      ac = bus.out_valid && ordy;
      act_met = bus.metrics; act_last = bus.out_last; act_ir = bus.in_ready;
      if (xf) begin
         model_step(mdl, mdl_mode, g1, g2, MW, mo);
         mdl = mo;
         mdl_n++;
         e.met = pack16(mo); e.last = (mdl_n == mdl_k);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode = 1'b0; init_sel = 1'b0; blk_len = '0;
      s8_start = 1'b0; s8_mode = 1'b0; s8_init = 1'b0; s8_len = '0;
      bus.in_valid = 1'b0; bus.gamma1 = '0; bus.gamma2 = '0; bus.out_ready = 1'b0;
      bus8.in_valid = 1'b0; bus8.gamma1 = '0; bus8.gamma2 = '0; bus8.out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      nchk++;
      if ({bus.out_valid, bus.out_last, busy, done, bus.in_ready} !== 5'b0)
         $display("FAIL reset_ctrl: ov/ol/busy/done/ir=%b want 00000",
                  {bus.out_valid, bus.out_last, busy, done, bus.in_ready});
      else npass++;
      nchk++;
      if (bus.metrics !== '0) $display("FAIL reset_metrics: got %h want 0", bus.metrics);
      else npass++;
      rst = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      nchk++;
      if ({bus.out_valid, busy, bus.in_ready} !== 3'b0)
         $display("FAIL idle_ignores_valid: ov/busy/ir=%b want 000", {bus.out_valid, busy, bus.in_ready});
      else npass++;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_fwd_known();
      bit xf, ac; int nacc, cyc; exp_t e; int kv [8];
`ifdef TRELLIS_METRIC_NORM_EN
      kv = '{0, -133, -133, -128, -20, -133, -133, -128};
`else
      kv = '{10, -123, -123, -118, -10, -123, -123, -118};
`endif
      do_start(1'b0, 1'b0, 1);
      nacc = 0; cyc = 0;
      while (nacc < 1 && cyc < 20) begin
         tick(mdl_n < 1, 10, 5, 1'b1, xf, ac); cyc++;
         if (ac) begin
            nacc++; nchk++;
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if ({act_last, act_met} !== e) $display("FAIL fwd_known_model: got %h/%b want %h/%b", act_met, act_last, e.met, e.last);
            else npass++;
            nchk++;
            if ({act_last, act_met} !== {1'b1, pack16(kv)}) $display("FAIL fwd_known_vec: got %h/%b want %h/1", act_met, act_last, pack16(kv));
            else npass++;
         end
      end
      nchk++;
      if ({busy, done} !== 2'b10) $display("FAIL fwd_done_early: busy/done=%b want 10", {busy, done}); else npass++;
      @(posedge clk); #1;
      nchk++;
      if ({busy, done, bus.out_valid} !== 3'b010) $display("FAIL fwd_done_pulse: busy/done/ov=%b want 010", {busy, done, bus.out_valid}); else npass++;
      @(posedge clk); #1;
      nchk++;
      if (done !== 1'b0) $display("FAIL fwd_done_width: done=%b want 0", done); else npass++;
   endtask

   task automatic test_bwd_uniform();
      bit xf, ac; int nacc, cyc; exp_t e; int kv [8];
`ifdef TRELLIS_METRIC_NORM_EN
      kv = '{0, 0, -1, -1, -1, -1, 0, 0};
`else
      kv = '{4, 4, 3, 3, 3, 3, 4, 4};
`endif
      do_start(1'b1, 1'b1, 1);
      nacc = 0; cyc = 0;
      while (nacc < 1 && cyc < 20) begin
         tick(mdl_n < 1, 4, -3, 1'b1, xf, ac); cyc++;
         if (ac) begin
            nacc++; nchk++;
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if ({act_last, act_met} !== {1'b1, pack16(kv)} || e.met !== pack16(kv))
               $display("FAIL bwd_known_vec: got %h/%b want %h/1", act_met, act_last, pack16(kv));
            else npass++;
         end
      end
      nchk++;
      if (nacc != 1) $display("FAIL bwd_known_count: outputs %0d want 1", nacc); else npass++;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bit xf, ac; int nacc, cyc, g1, g2; exp_t e;
      do_start(1'b0, 1'b0, 8);
      nacc = 0; cyc = 0;
      while (nacc < 8 && cyc < 40) begin
         g1 = int'($urandom_range(0, 6000)) - 3000;
         g2 = int'($urandom_range(0, 6000)) - 3000;
         tick(mdl_n < 8, g1, g2, 1'b1, xf, ac); cyc++;
         if (ac) begin
            nacc++; nchk++;
            if (sb.size() == 0) $display("FAIL b2b_fwd: output %0d with nothing expected", nacc);
            else begin
               e = sb.pop_front();
               if ({act_last, act_met} !== e) $display("FAIL b2b_fwd: got %h/%b want %h/%b", act_met, act_last, e.met, e.last);
               else npass++;
            end
         end
      end
      nchk++;
      if (cyc != 9) $display("FAIL b2b_throughput: cycles %0d want 9", cyc); else npass++;
      repeat (2) @(posedge clk); #1;
      // Backward recursion with random valid/ready gaps.
      do_start(1'b1, 1'b1, 6);
      nacc = 0; cyc = 0;
      while (nacc < 6 && cyc < 200) begin
         g1 = int'($urandom_range(0, 2000)) - 1000;
         g2 = int'($urandom_range(0, 2000)) - 1000;
         tick((mdl_n < 6) && ($urandom_range(0, 3) != 0), g1, g2, $urandom_range(0, 2) != 0, xf, ac); cyc++;
         if (ac) begin
            nacc++; nchk++;
            if (sb.size() == 0) $display("FAIL gaps_bwd: output %0d with nothing expected", nacc);
            else begin
               e = sb.pop_front();
               if ({act_last, act_met} !== e) $display("FAIL gaps_bwd: got %h/%b want %h/%b", act_met, act_last, e.met, e.last);
               else npass++;
            end
         end
      end
      nchk++;
      if (nacc != 6) $display("FAIL gaps_bwd_count: outputs %0d want 6", nacc); else npass++;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_stall();
      bit xf, ac, ordy, seen; int nacc, cyc, left; exp_t e; logic [8*MW-1:0] held;
      do_start(1'b0, 1'b0, 3);
      nacc = 0; cyc = 0; left = 0; seen = 1'b0; held = '0;
      while (nacc < 3 && cyc < 40) begin
         ordy = 1'b1;
         if (bus.out_valid && !seen) begin seen = 1'b1; left = 3; held = bus.metrics; end
         if (left > 0) begin ordy = 1'b0; left--; end
         if (cyc == 1) begin start = 1'b1; mode = 1'b1; blk_len = LW'(7); end
         tick(mdl_n < 3, 100 * (cyc + 1), -50 * cyc, ordy, xf, ac); cyc++;
         start = 1'b0;
         if (!ordy) begin
            nchk++;
            if (act_ir !== 1'b0 || act_met !== held || xf)
               $display("FAIL stall_hold: ir=%b metrics %h want ir=0 metrics %h", act_ir, act_met, held);
            else npass++;
         end
         if (ac) begin
            nacc++; nchk++;
            if (sb.size() == 0) $display("FAIL stall_out: output %0d with nothing expected", nacc);
            else begin
               e = sb.pop_front();
               if ({act_last, act_met} !== e) $display("FAIL stall_out: got %h/%b want %h/%b", act_met, act_last, e.met, e.last);
               else npass++;
            end
         end
      end
      nchk++;
      if ({busy, done, bus.out_valid} !== 3'b100) $display("FAIL stall_done_early: busy/done/ov=%b want 100", {busy, done, bus.out_valid}); else npass++;
      @(posedge clk); #1;
      nchk++;
      if ({busy, done, bus.out_valid} !== 3'b010) $display("FAIL stall_done_pulse: busy/done/ov=%b want 010", {busy, done, bus.out_valid}); else npass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit xf, ac; int nacc, cyc, seen_done; exp_t e;
      do_start(1'b0, 1'b0, 5);
      tick(1'b1, 300, -200, 1'b1, xf, ac);
      tick(1'b1, -150, 75, 1'b1, xf, ac);
      nchk++;
      if (mdl_n != 2) $display("FAIL rstmid_xfers: transfers %0d want 2", mdl_n); else npass++;
      rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      nchk++;
      if ({bus.out_valid, busy, bus.in_ready, done} !== 4'b0)
         $display("FAIL rstmid_state: ov/busy/ir/done=%b want 0000", {bus.out_valid, busy, bus.in_ready, done});
      else npass++;
      seen_done = 0;
      repeat (3) begin @(posedge clk); #1; if (done) seen_done++; end
      nchk++;
      if (seen_done != 0) $display("FAIL rstmid_no_done: done cycles %0d want 0", seen_done); else npass++;
      bus.in_valid = 1'b0;
      do_start(1'b0, 1'b0, 2);
      nacc = 0; cyc = 0;
      while (nacc < 2 && cyc < 20) begin
         tick(mdl_n < 2, 7 - 20 * cyc, 9 + 11 * cyc, 1'b1, xf, ac); cyc++;
         if (ac) begin
            nacc++; nchk++;
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if ({act_last, act_met} !== e) $display("FAIL rstmid_restart: got %h/%b want %h/%b", act_met, act_last, e.met, e.last);
            else npass++;
         end
      end
      nchk++;
      if (nacc != 2) $display("FAIL rstmid_restart_count: outputs %0d want 2", nacc); else npass++;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_zero_len();
      do_start(1'b0, 1'b0, 0);
      nchk++;
      if ({bus.out_valid, busy, done} !== 3'b010) $display("FAIL zero_len_s1: ov/busy/done=%b want 010", {bus.out_valid, busy, done}); else npass++;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nchk++;
      if ({bus.out_valid, busy, done} !== 3'b001) $display("FAIL zero_len_done: ov/busy/done=%b want 001", {bus.out_valid, busy, done}); else npass++;
      @(posedge clk); #1;
      nchk++;
      if ({bus.out_valid, busy, done} !== 3'b000) $display("FAIL zero_len_after: ov/busy/done=%b want 000", {bus.out_valid, busy, done}); else npass++;
   endtask

   task automatic test_saturation();
      exp8_t q8 [$]; exp8_t e; int m [8]; int mo [8]; int n_in, n_out, bad;
      logic signed [MW8-1:0] v;
      s8_start = 1'b1; s8_mode = 1'b0; s8_init = 1'b1; s8_len = LW'(4);
      @(posedge clk); #1;
      s8_start = 1'b0;
      for (int s = 0; s < 8; s++) m[s] = 0;
      n_in = 0; n_out = 0;
      for (int c = 0; c < 30 && n_out < 4; c++) begin
         bus8.in_valid = (n_in < 4); bus8.gamma1 = GW'(100); bus8.gamma2 = GW'(100); bus8.out_ready = 1'b1;
         #3;
         if (bus8.out_valid) begin
            n_out++; nchk++;
            e = (q8.size() != 0) ? q8.pop_front() : '0;
            if ({bus8.out_last, bus8.metrics} !== e) $display("FAIL sat_model: got %h/%b want %h/%b", bus8.metrics, bus8.out_last, e.met, e.last);
            else npass++;
            bad = 0;
            for (int s = 0; s < 8; s++) begin v = bus8.metrics[s*MW8 +: MW8]; if (v < 0) bad++; end
            nchk++;
            if (bad != 0) $display("FAIL sat_no_wrap: %0d negative metrics in %h", bad, bus8.metrics); else npass++;
`ifndef TRELLIS_METRIC_NORM_EN
            if (n_out >= 2) begin
               nchk++;
               v = bus8.metrics[MW8-1:0];
               if (v !== 8'sd127) $display("FAIL sat_clamp_n0: got %0d want 127", v); else npass++;
            end
`endif
         end
         if (bus8.in_valid && bus8.in_ready) begin
            model_step(m, 1'b0, 100, 100, MW8, mo);
            m = mo; n_in++;
            q8.push_back({n_in == 4, pack8(mo)});
         end
         @(posedge clk); #1;
      end
      bus8.in_valid = 1'b0;
      nchk++;
      if (n_out != 4) $display("FAIL sat_count: outputs %0d want 4", n_out); else npass++;
      repeat (2) @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fwd_known();
      test_bwd_uniform();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_zero_len();
      test_saturation();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
